// File: rtl/log_fixed_pkg.sv
// -----------------------------------------------------------------------------
// log_fixed_pkg
// Definitions shared by the log-domain units (log2_fixed_point and
// exp2_fixed_point):
//   LOG_INT_W / LOG_FRAC_W : default integer/fraction widths of a ufix log value
//   sat_max()              : largest unsigned value of a given output width
//   ufix_k() / ufix_f()    : extract the integer (k) and fraction (f) fields
//                            from a packed {k, f} log value
// -----------------------------------------------------------------------------
package log_fixed_pkg;

    localparam int LOG_INT_W  = 4;
    localparam int LOG_FRAC_W = 8;

    // All-ones value of an out_w-bit unsigned result (out_w must be <= 31).
    function automatic logic [31:0] sat_max(input int out_w);
        return (32'd1 << out_w) - 32'd1;
    endfunction

    // Integer field k of a {k, f} log value, zero-extended to 32 bits.
    function automatic logic [31:0] ufix_k(input logic [31:0] log_val,
                                           input int          int_w,
                                           input int          frac_w);
        return (log_val >> frac_w) & ((32'd1 << int_w) - 32'd1);
    endfunction

    // Fraction field f of a {k, f} log value, zero-extended to 32 bits.
    function automatic logic [31:0] ufix_f(input logic [31:0] log_val,
                                           input int          frac_w);
        return log_val & ((32'd1 << frac_w) - 32'd1);
    endfunction

endpackage

// File: rtl/exp2_fixed_point_if.sv
// -----------------------------------------------------------------------------
// exp2_fixed_point_if
// Stream bundle around the antilog unit.
//   i_LOG   : {k, f} log-domain input        i_VALID : input sample valid
//   o_READY : unit accepts i_LOG this cycle  o_VALUE : linear result
//   o_OVF   : result saturated               o_VALID : o_VALUE/o_OVF valid
//   i_READY : downstream accepts output
// modport slave  : the exp2 unit itself
// modport master : the environment (producer + consumer)
// -----------------------------------------------------------------------------
interface exp2_fixed_point_if
    import log_fixed_pkg::*;
#(
    parameter int INT_W  = LOG_INT_W,
    parameter int FRAC_W = LOG_FRAC_W,
    parameter int OUT_W  = 16
);

    logic [INT_W+FRAC_W-1:0] i_LOG;
    logic                    i_VALID;
    logic                    o_READY;
    logic [OUT_W-1:0]        o_VALUE;
    logic                    o_OVF;
    logic                    o_VALID;
    logic                    i_READY;

    modport slave (
        input  i_LOG, i_VALID, i_READY,
        output o_READY, o_VALUE, o_OVF, o_VALID
    );

    modport master (
        output i_LOG, i_VALID, i_READY,
        input  o_READY, o_VALUE, o_OVF, o_VALID
    );

endinterface

// File: rtl/exp2_shift_stage.sv
// -----------------------------------------------------------------------------
// exp2_shift_stage
// One registered pipeline stage: left-shifts data_in by a field of k, whose
// bit weight is FIELD_LSB (shift = field << FIELD_LSB), then drops DROP_LSB
// low bits before registering. Data and valid advance only when en is high.
//   clk, reset          : clock, asynchronous active-high reset
//   en                  : pipeline advance
//   valid_in / data_in  : upstream stage valid and data
//   field               : selected bits of k
//   valid_out/data_out  : registered valid and shifted data
// -----------------------------------------------------------------------------
module exp2_shift_stage #(
    parameter int IN_W      = 9,
    parameter int OUT_W     = 24,
    parameter int FIELD_W   = 2,
    parameter int FIELD_LSB = 0,
    parameter int DROP_LSB  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               valid_in,
    input  logic [IN_W-1:0]    data_in,
    input  logic [FIELD_W-1:0] field,
    output logic               valid_out,
    output logic [OUT_W-1:0]   data_out
);

    localparam int SH_W   = FIELD_W + FIELD_LSB;
    localparam int WIDE_W = OUT_W + DROP_LSB;

    logic [SH_W-1:0]   shamt;
    logic [WIDE_W-1:0] shifted;
    logic              valid_reg;
    logic [OUT_W-1:0]  data_reg;

    // The field keeps its positional weight, so a coarse stage shifts by
    // multiples of 2^FIELD_LSB only.
    assign shamt   = SH_W'(field) << FIELD_LSB;
    assign shifted = WIDE_W'(data_in) << shamt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (en) begin
            valid_reg <= valid_in;
            data_reg  <= shifted[WIDE_W-1:DROP_LSB];
        end
    end

    assign valid_out = valid_reg;
    assign data_out  = data_reg;

endmodule

// File: rtl/exp2_fixed_point.sv
// -----------------------------------------------------------------------------
// exp2_fixed_point
// Fixed-point antilog: for a log value {k, f} returns (1+f)*2^k truncated to an
// integer (Mitchell approximation), saturating at 2^OUT_W-1 with o_OVF set.
// Three registered stages:
//   1: mantissa m = {1, f}, k captured
//   2: coarse shift of m by k with its two low bits masked
//   3: fine shift by k[1:0] and drop of the FRAC_W fraction bits
// The whole pipeline advances together whenever the output slot is free or
// being consumed; bubbles are carried, not squeezed out.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : exp2_fixed_point_if.slave stream bundle
// -----------------------------------------------------------------------------
module exp2_fixed_point
    import log_fixed_pkg::*;
#(
    parameter int INT_W  = LOG_INT_W,
    parameter int FRAC_W = LOG_FRAC_W,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    exp2_fixed_point_if.slave bus
);

    localparam int M_W = FRAC_W + 1;
    // m shifted by at most 2^INT_W-1 stays lossless in this width.
    localparam int S_W = FRAC_W + (1 << INT_W);
    localparam int R_W = S_W - FRAC_W;
    localparam logic [31:0] SAT_MAX = sat_max(OUT_W);

    logic              adv;
    logic [INT_W-1:0]  k_in;
    logic [FRAC_W-1:0] f_in;

    logic              m_valid_reg;
    logic [M_W-1:0]    m_reg;
    logic [INT_W-1:0]  k_reg;
    logic [1:0]        k_lo_reg;

    logic              s_valid;
    logic [S_W-1:0]    s_data;
    logic              r_valid;
    logic [R_W-1:0]    r_data;

    logic [31:0]       r_ext;
    logic              ovf;

    // Free output slot or a consuming downstream lets everything move.
    assign adv         = bus.i_READY | ~r_valid;
    assign bus.o_READY = adv;

    assign k_in = INT_W'(ufix_k(32'(bus.i_LOG), INT_W, FRAC_W));
    assign f_in = FRAC_W'(ufix_f(32'(bus.i_LOG), FRAC_W));

    // Stage 1: restore the implicit leading one of the mantissa.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_reg <= 1'b0;
            m_reg       <= '0;
            k_reg       <= '0;
        end else if (adv) begin
            m_valid_reg <= bus.i_VALID;
            m_reg       <= {1'b1, f_in};
            k_reg       <= k_in;
        end
    end

    // Low bits of k travel alongside stage 2 for the fine shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_lo_reg <= '0;
        end else if (adv) begin
            k_lo_reg <= k_reg[1:0];
        end
    end

    // Stage 2: shift by k with its low two bits masked (0, 4, 8, ...).
    exp2_shift_stage #(
        .IN_W      (M_W),
        .OUT_W     (S_W),
        .FIELD_W   (INT_W - 2),
        .FIELD_LSB (2),
        .DROP_LSB  (0)
    ) u_coarse (
        .clk       (clk),
        .reset     (reset),
        .en        (adv),
        .valid_in  (m_valid_reg),
        .data_in   (m_reg),
        .field     (k_reg[INT_W-1:2]),
        .valid_out (s_valid),
        .data_out  (s_data)
    );

    // Stage 3: shift by k[1:0], then truncate away the fraction bits.
    exp2_shift_stage #(
        .IN_W      (S_W),
        .OUT_W     (R_W),
        .FIELD_W   (2),
        .FIELD_LSB (0),
        .DROP_LSB  (FRAC_W)
    ) u_fine (
        .clk       (clk),
        .reset     (reset),
        .en        (adv),
        .valid_in  (s_valid),
        .data_in   (s_data),
        .field     (k_lo_reg),
        .valid_out (r_valid),
        .data_out  (r_data)
    );

    // Saturation works from the registered integer result, so o_VALUE holds
    // steady for as long as the pipeline is stalled.
    assign r_ext = 32'(r_data);
    assign ovf   = (r_ext > SAT_MAX);

    assign bus.o_VALID = r_valid;
    assign bus.o_OVF   = ovf;
    assign bus.o_VALUE = ovf ? SAT_MAX[OUT_W-1:0] : OUT_W'(r_data);

endmodule

// File: tb/tb_exp2_fixed_point.sv
// -----------------------------------------------------------------------------
// tb_exp2_fixed_point
// Directed and randomized checks of exp2_fixed_point against an arithmetic
// reference ((2^FRAC_W + f) << k) >> FRAC_W with saturation. A 16-bit and a
// 12-bit output instance are exercised.
// -----------------------------------------------------------------------------
module tb_exp2_fixed_point;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] in_q[$];
    logic [15:0] got[$];

    exp2_fixed_point_if #(.INT_W(4), .FRAC_W(8), .OUT_W(16)) b0 ();
    exp2_fixed_point_if #(.INT_W(4), .FRAC_W(8), .OUT_W(12)) b12 ();

    exp2_fixed_point #(.INT_W(4), .FRAC_W(8), .OUT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    exp2_fixed_point #(.INT_W(4), .FRAC_W(8), .OUT_W(12)) u_dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (b12)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: linear value of a {k, f} log input, saturated to outw bits.
    function automatic void model(input logic [11:0] v, input int outw,
                                  output logic [63:0] val, output logic ovf);
        logic [63:0] k;
        logic [63:0] f;
        logic [63:0] r;
        logic [63:0] mx;
        k   = 64'(v[11:8]);
        f   = 64'(v[7:0]);
        r   = ((64'd256 + f) << k) >> 8;
        mx  = (64'd1 << outw) - 64'd1;
        ovf = (r > mx);
        val = ovf ? mx : r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted input is queued; every consumed output must
    // match the oldest queued input's reference value.
    always @(negedge clk) begin
        if (!reset) begin
            if (b0.o_VALID && b0.i_READY) begin
                chk("output_expected", 64'(in_q.size() != 0), 64'(1));
                if (in_q.size() != 0) begin
                    logic [11:0] x;
                    logic [63:0] ev;
                    logic        eo;
                    x = in_q.pop_front();
                    model(x, 16, ev, eo);
                    $display("tx log=%03h value=%0d ovf=%0d", x, b0.o_VALUE, b0.o_OVF);
                    chk("stream_value", 64'(b0.o_VALUE), ev);
                    chk("stream_ovf", 64'(b0.o_OVF), 64'(eo));
                    got.push_back(b0.o_VALUE);
                end
            end
            if (b0.i_VALID && b0.o_READY) begin
                in_q.push_back(b0.i_LOG);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        b0.i_LOG   = v;
        b0.i_VALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (b0.o_READY) break;
        end
        chk("send_accept", 64'(b0.o_READY), 64'(1));
        step();
        b0.i_VALID = 1'b0;
    endtask

    task automatic lat_check(input string tag, input logic [11:0] v, input logic [15:0] expv);
        send(v);
        chk({tag, "_lat1"}, 64'(b0.o_VALID), 64'(0));
        step();
        chk({tag, "_lat2"}, 64'(b0.o_VALID), 64'(0));
        step();
        chk({tag, "_lat3"}, 64'(b0.o_VALID), 64'(1));
        chk({tag, "_value"}, 64'(b0.o_VALUE), 64'(expv));
        chk({tag, "_ovf"}, 64'(b0.o_OVF), 64'(0));
    endtask

    task automatic send12(input string tag, input logic [11:0] v,
                          input logic [11:0] expv, input logic expo);
        b12.i_LOG   = v;
        b12.i_VALID = 1'b1;
        chk({tag, "_ready"}, 64'(b12.o_READY), 64'(1));
        step();
        b12.i_VALID = 1'b0;
        step();
        step();
        chk({tag, "_valid"}, 64'(b12.o_VALID), 64'(1));
        chk({tag, "_value"}, 64'(b12.o_VALUE), 64'(expv));
        chk({tag, "_ovf"}, 64'(b12.o_OVF), 64'(expo));
    endtask

    initial begin
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'd2;
        exp_seq[1] = 16'd4;
        exp_seq[2] = 16'd8;

        b0.i_LOG    = '0;
        b0.i_VALID  = 1'b0;
        b0.i_READY  = 1'b1;
        b12.i_LOG   = '0;
        b12.i_VALID = 1'b0;
        b12.i_READY = 1'b1;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_valid", 64'(b0.o_VALID), 64'(0));
        chk("rst_value", 64'(b0.o_VALUE), 64'(0));
        chk("rst_ovf", 64'(b0.o_OVF), 64'(0));
        chk("rst_ready", 64'(b0.o_READY), 64'(1));
        chk("rst12_valid", 64'(b12.o_VALID), 64'(0));
        chk("rst12_value", 64'(b12.o_VALUE), 64'(0));
        reset = 1'b0;
        step();

        // Directed values with 3-cycle latency
        lat_check("k0_f0", 12'h000, 16'd1);
        lat_check("k0_fmax", 12'h0FF, 16'd1);
        lat_check("k3_fhalf", 12'h380, 16'd12);
        lat_check("k10", 12'hA40, 16'd1280);
        lat_check("kmax_fmax", 12'hFFF, 16'd65408);
        step();

        // Saturation on the narrow instance
        send12("sat12", 12'hF00, 12'd4095, 1'b1);
        send12("nosat12", 12'hB00, 12'd2048, 1'b0);

        // Back-to-back stream with a downstream stall
        repeat (3) step();
        got.delete();
        send(12'h100);
        send(12'h200);
        send(12'h300);
        b0.i_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(b0.o_VALID), 64'(1));
            chk("stall_value", 64'(b0.o_VALUE), 64'(2));
            chk("stall_ready", 64'(b0.o_READY), 64'(0));
            step();
        end
        b0.i_READY = 1'b1;
        repeat (6) step();
        chk("stall_count", 64'(got.size()), 64'(3));
        for (int i = 0; i < got.size() && i < 3; i++) begin
            chk("stall_order", 64'(got[i]), 64'(exp_seq[i]));
        end

        // Reset with samples in flight
        got.delete();
        b0.i_READY = 1'b0;
        send(12'h500);
        send(12'h600);
        send(12'h700);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(b0.o_VALID), 64'(0));
        chk("midrst_value", 64'(b0.o_VALUE), 64'(0));
        in_q.delete();
        got.delete();
        repeat (2) step();
        reset      = 1'b0;
        b0.i_READY = 1'b1;
        step();
        lat_check("after_rst", 12'h400, 16'd16);
        repeat (6) step();
        chk("after_rst_count", 64'(got.size()), 64'(1));

        // Randomized valid/ready traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            b0.i_VALID = 1'($urandom_range(0, 1));
            b0.i_LOG   = 12'($urandom);
            b0.i_READY = ($urandom_range(0, 3) != 0);
            step();
        end
        b0.i_VALID = 1'b0;
        b0.i_READY = 1'b1;
        repeat (8) step();
        chk("drain_empty", 64'(in_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
